// File: rtl/arch_state_dump.sv
// arch_state_dump: streams retired PCs through a small FIFO, then dumps every
// architectural register through the selected RAT, then one summary record.
module arch_state_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARCH_REGS  = 32,
  parameter int PHY_REGS   = 64,
  parameter int PHY_WIDTH  = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_CYCLES = 30000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            retire_valid,
  input  logic [ADDR_WIDTH-1:0]           retire_addr,
  input  logic                            done,
  input  logic                            dump_req,
  input  logic                            dump_sel,
  input  logic [PHY_REGS*DATA_WIDTH-1:0]  PRF_data_in,
  input  logic [PHY_WIDTH*ARCH_REGS-1:0]  front_rat_in,
  input  logic [PHY_WIDTH*ARCH_REGS-1:0]  back_rat_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [1:0]                      out_type,
  output logic [4:0]                      out_index,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [31:0]                     retire_count,
  output logic [31:0]                     drop_count,
  output logic                            finished
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(ARCH_REGS);
  localparam logic [1:0]       T_RETIRE  = 2'd0;
  localparam logic [1:0]       T_REG     = 2'd1;
  localparam logic [1:0]       T_SUMMARY = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ARCH_REGS - 1);
  localparam logic [31:0]      LIMIT     = 32'(MAX_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_RUN, S_DRAIN, S_DUMP, S_SUMMARY, S_FINISHED} state_t;

  typedef struct packed {
    logic [1:0]            typ;
    logic [4:0]            index;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  // Flat buses share bit layout with these packed arrays: entry j at [j*W +: W].
  logic [PHY_REGS-1:0][DATA_WIDTH-1:0]  prf;
  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]  frat, brat;
  assign prf  = PRF_data_in;
  assign frat = front_rat_in;
  assign brat = back_rat_in;

  state_t state, state_n;
  rec_t   out_rec, rec_n;

  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [31:0]      cycle_cnt, trig_cycle;
  logic [IDX_W-1:0] idx;
  logic             sel, overflow;

  logic can_load, fifo_empty, fifo_full, in_stream;
  logic pop, push_req, push, drop;
  logic ld, trig, trig_sel, idx_inc;
  logic [PHY_WIDTH-1:0] rat_tag;

  assign can_load   = !out_valid || out_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign in_stream  = (state == S_RUN) || (state == S_DRAIN);
  assign pop        = in_stream && !fifo_empty && can_load;
  assign push_req   = (state == S_RUN) && retire_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign rat_tag    = sel ? frat[idx] : brat[idx];

  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    rec_n    = '0;
    trig     = 1'b0;
    trig_sel = 1'b0;
    idx_inc  = 1'b0;
    if (pop) begin
      ld         = 1'b1;
      rec_n.typ  = T_RETIRE;
      rec_n.data = DATA_WIDTH'(fifo_mem[rd_ptr]);
    end
    case (state)
      S_RUN: begin
        if (done) begin
          trig     = 1'b1;
          trig_sel = 1'b1;
        end else if (dump_req) begin
          trig     = 1'b1;
          trig_sel = dump_sel;
        end else if (cycle_cnt == LIMIT) begin
          trig     = 1'b1;
          trig_sel = 1'b0;
        end
        if (trig) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && can_load) state_n = S_DUMP;
      end
      S_DUMP: begin
        if (can_load) begin
          ld          = 1'b1;
          rec_n.typ   = T_REG;
          rec_n.index = 5'(idx);
          rec_n.data  = prf[rat_tag];
          idx_inc     = 1'b1;
          if (idx == LAST_IDX) state_n = S_SUMMARY;
        end
      end
      S_SUMMARY: begin
        // Output register still holds either the last REG or the SUMMARY itself.
        if (out_valid && out_rec.typ == T_SUMMARY) begin
          if (out_ready) state_n = S_FINISHED;
        end else if (can_load) begin
          ld          = 1'b1;
          rec_n.typ   = T_SUMMARY;
          rec_n.index = {3'b000, sel, overflow};
          rec_n.data  = DATA_WIDTH'(trig_cycle);
        end
      end
      S_FINISHED: ;
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_RUN;
      out_valid    <= 1'b0;
      out_rec      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      cycle_cnt    <= '0;
      trig_cycle   <= '0;
      retire_count <= '0;
      drop_count   <= '0;
      idx          <= '0;
      sel          <= 1'b0;
      overflow     <= 1'b0;
      finished     <= 1'b0;
    end else begin
      state    <= state_n;
      finished <= (state_n == S_FINISHED);
      if (ld) begin
        out_valid <= 1'b1;
        out_rec   <= rec_n;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
      if (push_req) retire_count <= retire_count + 32'd1;
      if (drop) begin
        drop_count <= drop_count + 32'd1;
        overflow   <= 1'b1;
      end
      if (state == S_RUN) begin
        if (trig) begin
          trig_cycle <= cycle_cnt;
          sel        <= trig_sel;
        end else begin
          cycle_cnt  <= cycle_cnt + 32'd1;
        end
      end
      if (state == S_DRAIN) idx <= '0;
      else if (idx_inc)     idx <= idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= retire_addr;
  end

  assign out_type  = out_rec.typ;
  assign out_index = out_rec.index;
  assign out_data  = out_rec.data;

endmodule

// File: tb/tb_arch_state_dump.sv
// Scoreboard bench for arch_state_dump: a stream-level model queues expected
// records; an independent monitor pops and compares on every handshake.
module tb_arch_state_dump;
  localparam int DW = 32, AW = 32, AR = 32, PR = 64, PW = 6, FD = 8, MC = 100;

  logic clk = 1'b0, rst = 1'b1;
  logic retire_valid = 1'b0, done = 1'b0, dump_req = 1'b0, dump_sel = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] retire_addr = '0;
  logic [PR*DW-1:0] PRF_data_in = '0;
  logic [PW*AR-1:0] front_rat_in = '0, back_rat_in = '0;
  logic out_valid, finished;
  logic [1:0] out_type;
  logic [4:0] out_index;
  logic [DW-1:0] out_data;
  logic [31:0] retire_count, drop_count;

  arch_state_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARCH_REGS(AR), .PHY_REGS(PR),
                    .PHY_WIDTH(PW), .FIFO_DEPTH(FD), .MAX_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_addr(retire_addr),
    .done(done), .dump_req(dump_req), .dump_sel(dump_sel), .PRF_data_in(PRF_data_in),
    .front_rat_in(front_rat_in), .back_rat_in(back_rat_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_type(out_type), .out_index(out_index), .out_data(out_data),
    .retire_count(retire_count), .drop_count(drop_count), .finished(finished));

  always #5 clk = ~clk;

  typedef struct { logic [1:0] t; logic [4:0] i; logic [31:0] d; } rec_t;
  rec_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int unsigned prf_m[PR];
  int unsigned frat_m[AR], brat_m[AR];
  int m_cyc, m_ret, m_drop, m_occ;
  bit m_run, m_ovf, m_trig, m_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Stream model. Records held by the unit = FIFO + output register; a
  // retirement is lost only when that total is FIFO_DEPTH+1 and the consumer stalls.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_cyc = 0; m_ret = 0; m_drop = 0; m_occ = 0; m_run = 1; m_ovf = 0;
    end else begin
      if (m_run) begin
        m_trig = done || dump_req || (m_cyc == MC - 1);
        m_sel  = done ? 1'b1 : (dump_req ? dump_sel : 1'b0);
        if (retire_valid) begin
          m_ret++;
          if (m_occ < FD + 1 || out_ready) begin
            exp_q.push_back('{2'd0, 5'd0, retire_addr});
            m_occ++;
          end else begin
            m_drop++;
            m_ovf = 1;
          end
        end
        if (m_trig) begin
          m_run = 0;
          for (int i = 0; i < AR; i++)
            exp_q.push_back('{2'd1, 5'(i), prf_m[m_sel ? frat_m[i] : brat_m[i]]});
          exp_q.push_back('{2'd2, {3'b000, m_sel, m_ovf}, 32'(m_cyc)});
        end else begin
          m_cyc++;
        end
      end
      if (out_valid && out_ready) m_occ--;
    end
  end

  always @(negedge clk) begin
    rec_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", {out_type, out_index, 25'd0}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rec_type", 32'(out_type), 32'(e.t));
        chk("rec_index", 32'(out_index), 32'(e.i));
        chk("rec_data", out_data, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_state();
    for (int j = 0; j < PR; j++) PRF_data_in[j*DW +: DW] = prf_m[j];
    for (int i = 0; i < AR; i++) begin
      front_rat_in[i*PW +: PW] = PW'(frat_m[i]);
      back_rat_in[i*PW +: PW]  = PW'(brat_m[i]);
    end
  endtask

  task automatic set_regs(input int back_off);
    for (int j = 0; j < PR; j++) prf_m[j] = (j < AR) ? 32'h100 + j : $urandom;
    for (int i = 0; i < AR; i++) begin
      frat_m[i] = i;
      brat_m[i] = (back_off >= 0) ? i + back_off : $urandom_range(0, PR - 1);
    end
    drive_state();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    retire_valid = 0; done = 0; dump_req = 0; dump_sel = 0; out_ready = 0; retire_addr = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_finish(input string nm, input bit rr);
    for (int k = 0; k < 3000 && !finished; k++) begin
      if (rr) out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk({nm, "_finished"}, 32'(finished), 32'd1);
    chk({nm, "_valid_low"}, 32'(out_valid), 32'd0);
    chk({nm, "_retire_count"}, retire_count, 32'(m_ret));
    chk({nm, "_drop_count"}, drop_count, 32'(m_drop));
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    set_regs(32);
    #2 rst = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_type", 32'(out_type), 0);
    chk("rst_index", 32'(out_index), 0);
    chk("rst_data", out_data, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_finished", 32'(finished), 0);
    tick(); tick();
    rst = 1'b1;

    // Three back-to-back retirements, each visible two edges later.
    out_ready = 1;
    retire_valid = 1; retire_addr = 32'h0; tick();
    retire_addr = 32'h4; tick();
    chk("t1_lat0", out_data, 32'h0);
    retire_addr = 32'h8; tick();
    chk("t1_lat1", out_data, 32'h4);
    retire_valid = 0; tick();
    chk("t1_lat2", out_data, 32'h8);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_retire_count", retire_count, 3);
    dump_req = 1; dump_sel = 1'($urandom); tick(); dump_req = 0;
    wait_finish("t1", 1);

    // Overflow with consumer stalled.
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 12; k++) begin
      retire_valid = 1; retire_addr = $urandom; tick();
    end
    retire_valid = 0;
    chk("t2_drop_count", drop_count, 3);
    chk("t2_retire_count", retire_count, 12);
    dump_req = 1; dump_sel = 1'($urandom); tick(); dump_req = 0;
    out_ready = 1;
    wait_finish("t2", 0);

    // done at cycle 50 through the front RAT, with a quiet lead-in for latency.
    set_regs(-1);
    do_reset();
    for (int k = 0; k < 38; k++) begin
      retire_valid = $urandom_range(0, 1); retire_addr = $urandom;
      out_ready = ($urandom_range(0, 3) != 0); tick();
    end
    retire_valid = 0; out_ready = 1;
    for (int k = 0; k < 12; k++) tick();
    done = 1; tick(); done = 0;
    tick();
    tick();
    chk("t3_first_reg_valid", 32'(out_valid), 1);
    chk("t3_first_reg_type", 32'(out_type), 1);
    chk("t3_first_reg_index", 32'(out_index), 0);
    wait_finish("t3", 1);

    // Cycle-limit trigger via the back RAT.
    set_regs(32);
    do_reset();
    for (int k = 0; k < 110; k++) begin
      retire_valid = ($urandom_range(0, 3) != 0); retire_addr = $urandom;
      out_ready = 1'($urandom_range(0, 1)); tick();
    end
    retire_valid = 0;
    wait_finish("t4", 1);

    // done beats dump_req(sel=0) with three entries queued.
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      retire_valid = 1; retire_addr = $urandom; tick();
    end
    retire_valid = 0;
    done = 1; dump_req = 1; dump_sel = 0; tick();
    done = 0; dump_req = 0; out_ready = 1;
    wait_finish("t5", 0);

    // Asynchronous reset in the middle of the dump.
    do_reset();
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      retire_valid = 1; retire_addr = $urandom; tick();
    end
    retire_valid = 0; dump_req = 1; tick(); dump_req = 0;
    for (int k = 0; k < 200 && !(out_valid && out_type == 2'd1 && out_index == 5'd10); k++) tick();
    chk("t6_reached_idx10", 32'(out_index), 10);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(out_valid), 0);
    chk("t6_data_zero", out_data, 0);
    chk("t6_retire_zero", retire_count, 0);
    chk("t6_drop_zero", drop_count, 0);
    chk("t6_finished_zero", 32'(finished), 0);
    tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      retire_valid = 1'($urandom_range(0, 1)); retire_addr = $urandom; tick();
    end
    retire_valid = 0; dump_req = 1; dump_sel = 1'($urandom); tick(); dump_req = 0;
    wait_finish("t6", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
